// File: rtl/input_debounce_buf.sv
// input_debounce_buf: synchroniser + debounce FSM for one raw external pin.
// The clean level Y feeds the downstream single-bit buffer gate; rise/fall are
// one-cycle strobes on each accepted transition.
// Optional build macro INPUT_DEBOUNCE_BUF_GLITCH_CNT_EN adds a saturating
// count of aborted transitions (glitch_cnt) with a synchronous clear (glitch_clr).
module input_debounce_buf #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
`ifdef INPUT_DEBOUNCE_BUF_GLITCH_CNT_EN
  input  logic       glitch_clr,
  output logic [7:0] glitch_cnt,
`endif
  output logic       Y,
  output logic       rise,
  output logic       fall,
  output logic       busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    PEND_H = 2'd1,
    HIGH   = 2'd2,
    PEND_L = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  // Synchroniser chain: A enters at bit 0, s is taken from the last flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], A};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Busy is a direct decode of the pending states, so it has no extra latency.
  assign busy = (state == PEND_H) || (state == PEND_L);

  // Debounce FSM with registered level and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      Y     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        LOW: begin
          if (s) begin
            state <= PEND_H;
            cnt   <= CNT_W'(1);
          end
        end
        PEND_H: begin
          if (!s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= HIGH;
            cnt   <= '0;
            Y     <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= PEND_L;
            cnt   <= CNT_W'(1);
          end
        end
        PEND_L: begin
          if (s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= LOW;
            cnt   <= '0;
            Y     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef INPUT_DEBOUNCE_BUF_GLITCH_CNT_EN
  logic abort;

  assign abort = ((state == PEND_H) && !s) || ((state == PEND_L) && s);

  // Saturating count of discarded transitions; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || glitch_clr) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_debounce_buf.sv
// Bench for input_debounce_buf: cycle-by-cycle vector table on a default
// instance, plus latency and short-pulse sequences on two re-parameterised ones.
module tb_input_debounce_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, a, a_sw;
  logic y, rise, fall, busy;
  logic y2, r2, f2, b2;
  logic y16, r16, f16, b16;

  int passed = 0;
  int total  = 0;

  input_debounce_buf u_def (
    .clk(clk), .rst(rst), .A(a), .Y(y), .rise(rise), .fall(fall), .busy(busy)
  );

  input_debounce_buf #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) u_d2 (
    .clk(clk), .rst(rst), .A(a_sw), .Y(y2), .rise(r2), .fall(f2), .busy(b2)
  );

  input_debounce_buf #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_d16 (
    .clk(clk), .rst(rst), .A(a_sw), .Y(y16), .rise(r16), .fall(f16), .busy(b16)
  );

  // One record per clock edge: inputs applied before the edge, {Y,rise,fall,busy} after it.
  typedef struct {
    logic       a;
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic va, input logic vr, input logic [3:0] ve);
    vec_t v;
    v.a = va;
    v.rst = vr;
    v.exp = ve;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat2, lat16, rises2, rises16, max_y16, seen_b16, max_y2;
    logic bounce_a[10];
    logic bounce_b[10];
    logic settle_a[9];
    logic [3:0] settle_e[9];

    rst  = 1'b1;
    a    = 1'b0;
    a_sw = 1'b0;

    // Reset held with A=1: everything quiet.
    repeat (3) add(1'b1, 1'b1, 4'b0000);
    // Release: rise after edge 5.
    add(1'b1, 1'b0, 4'b0000); add(1'b1, 1'b0, 4'b0000);
    repeat (3) add(1'b1, 1'b0, 4'b0001);
    add(1'b1, 1'b0, 4'b1100);
    add(1'b1, 1'b0, 4'b1000); add(1'b1, 1'b0, 4'b1000);
    // Release of the button: fall after edge 5.
    add(1'b0, 1'b0, 4'b1000); add(1'b0, 1'b0, 4'b1000);
    repeat (3) add(1'b0, 1'b0, 4'b1001);
    add(1'b0, 1'b0, 4'b0010);
    add(1'b0, 1'b0, 4'b0000);
    // Bounce 1,0,1,1,0,1 then 0: Y never rises.
    bounce_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bounce_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) add(bounce_a[i], 1'b0, {3'b000, bounce_b[i]});
    // Bounce 1,0,1 then held: one rise 5 edges after the final 0->1.
    settle_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    settle_e = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001,
                 4'b0001, 4'b1100, 4'b1000};
    for (int i = 0; i < 9; i++) add(settle_a[i], 1'b0, settle_e[i]);
    // Reset mid-debounce.
    add(1'b0, 1'b1, 4'b0000);
    add(1'b1, 1'b0, 4'b0000); add(1'b1, 1'b0, 4'b0000);
    add(1'b1, 1'b0, 4'b0001); add(1'b1, 1'b0, 4'b0001);
    add(1'b1, 1'b1, 4'b0000); add(1'b1, 1'b1, 4'b0000);
    add(1'b1, 1'b0, 4'b0000); add(1'b1, 1'b0, 4'b0000);
    repeat (3) add(1'b1, 1'b0, 4'b0001);
    add(1'b1, 1'b0, 4'b1100);
    add(1'b1, 1'b0, 4'b1000);
    // Toggle every cycle from HIGH: Y stays 1.
    for (int i = 0; i < 8; i++) add(1'(i % 2), 1'b0, {3'b100, 1'((i >= 2) && (i % 2 == 0))});
    add(1'b1, 1'b0, 4'b1001);
    add(1'b1, 1'b0, 4'b1000);
    add(1'b1, 1'b0, 4'b1000);

    for (int i = 0; i < vecs.size(); i++) begin
      a   = vecs[i].a;
      rst = vecs[i].rst;
      edge1();
      check($sformatf("vec%0d", i), int'({y, rise, fall, busy}), int'(vecs[i].exp));
    end

    // Latency sweep on the re-parameterised instances.
    rst  = 1'b1;
    a_sw = 1'b0;
    edge1();
    rst  = 1'b0;
    a_sw = 1'b1;
    lat2 = -1; lat16 = -1; rises2 = 0; rises16 = 0;
    for (int n = 0; n < 40; n++) begin
      edge1();
      if (y2 && lat2 < 0) lat2 = n;
      if (y16 && lat16 < 0) lat16 = n;
      rises2  += int'(r2);
      rises16 += int'(r16);
    end
    check("latency_d2_s3", lat2, 4);
    check("latency_d16", lat16, 17);
    check("rise_count_d2", rises2, 1);
    check("rise_count_d16", rises16, 1);

    // 15-cycle pulse is one sample short for DEBOUNCE_CYCLES=16.
    rst  = 1'b1;
    a_sw = 1'b0;
    edge1();
    rst  = 1'b0;
    a_sw = 1'b1;
    max_y16 = 0; seen_b16 = 0; max_y2 = 0;
    for (int n = 0; n < 40; n++) begin
      edge1();
      if (n == 14) a_sw = 1'b0;
      if (y16) max_y16 = 1;
      if (b16) seen_b16 = 1;
      if (y2) max_y2 = 1;
    end
    check("short_pulse_y_d16", max_y16, 0);
    check("short_pulse_busy_d16", seen_b16, 1);
    check("short_pulse_y_d2", max_y2, 1);
    check("final_y_d16", int'(y16), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
